// File: rtl/cycle_sequencer.sv
// cycle_sequencer
// Owns the micro-cycle counter, the latched opcode and the sticky halt/fault
// flags, and turns the decoded control state into one-hot datapath strobes.
// The state codes below are shared with the control decoder.

module cycle_sequencer #(
    parameter int CYCLE_W   = 4,
    parameter int MAX_CYCLE = 7,
    parameter int OPCODE_W  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                step_en,
    input  logic [3:0]          state,
    input  logic [7:0]          bus_in,
    output logic [CYCLE_W-1:0]  cycle,
    output logic [OPCODE_W-1:0] opcode,
    output logic                pc_inc,
    output logic                pc_load,
    output logic                mar_load,
    output logic                ram_oe,
    output logic                a_load,
    output logic                b_load,
    output logic                alu_oe,
    output logic                alu_sub,
    output logic                out_load,
    output logic                halted,
    output logic                fault
);

    localparam logic [3:0] STATE_NEXT       = 4'd0;
    localparam logic [3:0] STATE_FETCH_PC   = 4'd1;
    localparam logic [3:0] STATE_FETCH_INST = 4'd2;
    localparam logic [3:0] STATE_FETCH_ARG  = 4'd3;
    localparam logic [3:0] STATE_LOAD_Z     = 4'd4;
    localparam logic [3:0] STATE_RAM_A      = 4'd5;
    localparam logic [3:0] STATE_RAM_B      = 4'd6;
    localparam logic [3:0] STATE_ADD        = 4'd7;
    localparam logic [3:0] STATE_SUB        = 4'd8;
    localparam logic [3:0] STATE_OUT_A      = 4'd9;
    localparam logic [3:0] STATE_JUMP_Z     = 4'd10;
    localparam logic [3:0] STATE_HALT       = 4'd11;

    localparam logic [CYCLE_W-1:0] LAST_CYCLE = CYCLE_W'(MAX_CYCLE);

    logic running;
    logic strobe_en;

    // A halted or faulted machine is frozen; only reset brings it back.
    assign running   = step_en && !halted && !fault;
    assign strobe_en = running && !reset;

    // Cycle counter, opcode latch and sticky flags; advance only while running.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle  <= '0;
            opcode <= '0;
            halted <= 1'b0;
            fault  <= 1'b0;
        end else if (running) begin
            if (state == STATE_FETCH_INST) begin
                opcode <= OPCODE_W'(bus_in[7:4]);
            end
            if (state == STATE_HALT) begin
                halted <= 1'b1;
            end else if (state == STATE_NEXT) begin
                cycle <= '0;
            end else if (cycle < LAST_CYCLE) begin
                cycle <= cycle + CYCLE_W'(1);
            end else begin
                cycle <= '0;
                fault <= 1'b1;
            end
        end
    end

    // Decode the control state into datapath strobes, gated off when not stepping.
    always_comb begin
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        mar_load = 1'b0;
        ram_oe   = 1'b0;
        a_load   = 1'b0;
        b_load   = 1'b0;
        alu_oe   = 1'b0;
        alu_sub  = 1'b0;
        out_load = 1'b0;
        if (strobe_en) begin
            case (state)
                STATE_FETCH_PC: begin
                    mar_load = 1'b1;
                end
                STATE_FETCH_INST: begin
                    ram_oe = 1'b1;
                    pc_inc = 1'b1;
                end
                STATE_FETCH_ARG: begin
                    ram_oe   = 1'b1;
                    mar_load = 1'b1;
                    pc_inc   = 1'b1;
                end
                STATE_LOAD_Z: begin
                    ram_oe   = 1'b1;
                    mar_load = 1'b1;
                end
                STATE_RAM_A: begin
                    ram_oe = 1'b1;
                    a_load = 1'b1;
                end
                STATE_RAM_B: begin
                    ram_oe = 1'b1;
                    b_load = 1'b1;
                end
                STATE_ADD: begin
                    alu_oe = 1'b1;
                    a_load = 1'b1;
                end
                STATE_SUB: begin
                    alu_oe  = 1'b1;
                    alu_sub = 1'b1;
                    a_load  = 1'b1;
                end
                STATE_OUT_A: begin
                    out_load = 1'b1;
                end
                STATE_JUMP_Z: begin
                    ram_oe  = 1'b1;
                    pc_load = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cycle_sequencer.sv
// tb_cycle_sequencer
// Drives cycle_sequencer with a small stand-in control decoder and checks it
// against a behavioural model through an expected-value queue.

module tb_cycle_sequencer;

    localparam logic [3:0] S_NEXT = 4'd0,  S_FPC = 4'd1,  S_FINST = 4'd2, S_FARG = 4'd3;
    localparam logic [3:0] S_LDZ  = 4'd4,  S_RAMA = 4'd5, S_RAMB = 4'd6,  S_ADD = 4'd7;
    localparam logic [3:0] S_SUB  = 4'd8,  S_OUTA = 4'd9, S_JMPZ = 4'd10, S_HALT = 4'd11;

    localparam logic [3:0] OP_NOP = 4'd0, OP_LDA = 4'd1, OP_ADD = 4'd2, OP_SUB = 4'd3;
    localparam logic [3:0] OP_OUT = 4'd4, OP_JZ = 4'd5, OP_HLT = 4'd15;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       step_en = 1'b0;
    logic [3:0] state = 4'd0;
    logic [7:0] bus_in = 8'd0;
    logic [3:0] cycle, opcode;
    logic       pc_inc, pc_load, mar_load, ram_oe, a_load, b_load, alu_oe, alu_sub, out_load;
    logic       halted, fault;

    cycle_sequencer #(.CYCLE_W(4), .MAX_CYCLE(7), .OPCODE_W(4)) dut (
        .clk(clk), .reset(reset), .step_en(step_en), .state(state), .bus_in(bus_in),
        .cycle(cycle), .opcode(opcode), .pc_inc(pc_inc), .pc_load(pc_load),
        .mar_load(mar_load), .ram_oe(ram_oe), .a_load(a_load), .b_load(b_load),
        .alu_oe(alu_oe), .alu_sub(alu_sub), .out_load(out_load),
        .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] cyc;
        logic [3:0] op;
        logic       h;
        logic       f;
        logic [8:0] stb;
    } exp_t;

    exp_t       expq[$];
    event       sample_ev;
    int         n_vec = 0;
    int         n_bad = 0;
    logic [8:0] strobe_tab [16];

    // Reference model state: what the sequencer should hold right now.
    int         m_cycle = 0;
    logic [3:0] m_op = 4'd0;
    logic       m_halt = 1'b0;
    logic       m_fault = 1'b0;

    // Strobe table, bits {pc_inc,pc_load,mar_load,ram_oe,a_load,b_load,alu_oe,alu_sub,out_load}.
    initial begin
        for (int i = 0; i < 16; i++) strobe_tab[i] = 9'b0;
        strobe_tab[S_FPC]   = 9'b001000000;
        strobe_tab[S_FINST] = 9'b100100000;
        strobe_tab[S_FARG]  = 9'b101100000;
        strobe_tab[S_LDZ]   = 9'b001100000;
        strobe_tab[S_RAMA]  = 9'b000110000;
        strobe_tab[S_RAMB]  = 9'b000101000;
        strobe_tab[S_ADD]   = 9'b000010100;
        strobe_tab[S_SUB]   = 9'b000010110;
        strobe_tab[S_OUTA]  = 9'b000000001;
        strobe_tab[S_JMPZ]  = 9'b010100000;
    end

    // Stand-in control decoder: the state to present for a given opcode and cycle.
    function automatic logic [3:0] decode(input logic [3:0] op, input int cyc);
        logic [3:0] lda [7];
        logic [3:0] alu [8];
        lda = '{S_FPC, S_FINST, S_FPC, S_FARG, S_LDZ, S_RAMA, S_NEXT};
        alu = '{S_FPC, S_FINST, S_FPC, S_FARG, S_LDZ, S_RAMB, S_ADD, S_NEXT};
        if (cyc == 0) return S_FPC;
        if (cyc == 1) return S_FINST;
        case (op)
            OP_LDA:  return (cyc < 7) ? lda[cyc] : S_NEXT;
            OP_ADD:  return alu[cyc];
            OP_SUB:  return (cyc == 6) ? S_SUB : alu[cyc];
            OP_OUT:  return (cyc == 2) ? S_OUTA : S_NEXT;
            OP_JZ:   return (cyc == 2) ? S_FPC : (cyc == 3) ? S_JMPZ : S_NEXT;
            OP_HLT:  return S_HALT;
            default: return S_NEXT;
        endcase
    endfunction

    task automatic model_clear();
        m_cycle = 0;
        m_op    = 4'd0;
        m_halt  = 1'b0;
        m_fault = 1'b0;
    endtask

    task automatic push_expected(input logic [8:0] stb);
        exp_t e;
        e.cyc = 4'(m_cycle);
        e.op  = m_op;
        e.h   = m_halt;
        e.f   = m_fault;
        e.stb = stb;
        expq.push_back(e);
        ->sample_ev;
    endtask

    // One clock of stimulus: present inputs, queue expectation, advance the model at the edge.
    task automatic apply_stimulus(input logic en, input logic force_st, input logic [3:0] fst,
                                  input logic [3:0] opsel);
        logic [3:0] st;
        logic [7:0] r;
        @(negedge clk);
        st = force_st ? fst : decode(m_op, m_cycle);
        r  = 8'($urandom);
        step_en = en;
        state   = st;
        bus_in  = (st == S_FINST) ? {opsel, r[3:0]} : r;
        push_expected((en && !m_halt && !m_fault) ? strobe_tab[st] : 9'b0);
        @(posedge clk);
        if (en && !m_halt && !m_fault) begin
            if (st == S_FINST) m_op = bus_in[7:4];
            if (st == S_HALT) m_halt = 1'b1;
            else if (st == S_NEXT) m_cycle = 0;
            else if (m_cycle == 7) begin
                m_cycle = 0;
                m_fault = 1'b1;
            end else m_cycle = m_cycle + 1;
        end
    endtask

    // Reset with step_en high and a strobing state; everything must read zero.
    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b1;
        step_en = 1'b1;
        state   = S_FINST;
        bus_in  = 8'hF0;
        model_clear();
        push_expected(9'b0);
        @(negedge clk);
        reset   = 1'b0;
        step_en = 1'b0;
    endtask

    // Run one instruction to completion, optionally pausing step_en at one cycle.
    task automatic run_instr(input logic [3:0] opsel, input int hold_at, input int hold_len);
        int guard;
        int held;
        logic en;
        guard = 0;
        held  = 0;
        do begin
            en = 1'b1;
            if (m_cycle == hold_at && held < hold_len) begin
                en = 1'b0;
                held++;
            end
            apply_stimulus(en, 1'b0, 4'd0, opsel);
            guard++;
        end while (m_cycle != 0 && !m_halt && !m_fault && guard < 40);
    endtask

    // Monitor: pop one expectation for every presented sample and compare.
    task automatic check_output();
        exp_t e;
        logic [8:0] act;
        logic bad;
        act = {pc_inc, pc_load, mar_load, ram_oe, a_load, b_load, alu_oe, alu_sub, out_load};
        n_vec++;
        if (expq.size() == 0) begin
            $display("[TB] FAIL queue: sample with no expectation, actual cycle=%0d", cycle);
            n_bad++;
            return;
        end
        e = expq.pop_front();
        bad = 1'b0;
        if (cycle !== e.cyc) begin
            $display("[TB] FAIL cycle: actual %0d expected %0d", cycle, e.cyc);
            bad = 1'b1;
        end
        if (opcode !== e.op) begin
            $display("[TB] FAIL opcode: actual %0d expected %0d", opcode, e.op);
            bad = 1'b1;
        end
        if (halted !== e.h || fault !== e.f) begin
            $display("[TB] FAIL flags: actual halted=%b fault=%b expected halted=%b fault=%b",
                     halted, fault, e.h, e.f);
            bad = 1'b1;
        end
        if (act !== e.stb) begin
            $display("[TB] FAIL strobes: actual %b expected %b (cycle %0d)", act, e.stb, e.cyc);
            bad = 1'b1;
        end
        if (bad) n_bad++;
    endtask

    // Sample one time unit after each stimulus update, well away from the clock edge.
    initial begin
        forever begin
            @(sample_ev);
            #1;
            check_output();
        end
    end

    // Watchdog so a stuck run still ends with a verdict.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, actual queue=%0d required 0",
                 expq.size());
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] prog [7];
        prog = '{OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_JZ, OP_NOP, 4'd7};

        do_reset();
        foreach (prog[i]) run_instr(prog[i], -1, 0);

        // Single-step: pause five clocks at cycle 3 of an LDA.
        run_instr(OP_LDA, 3, 5);

        // Halt: cycle freezes at 2 and strobes stay off.
        run_instr(OP_HLT, -1, 0);
        for (int i = 0; i < 20; i++) apply_stimulus(1'b1, 1'b0, 4'd0, OP_NOP);

        // Runaway: constant FETCH_ARG overruns and faults.
        do_reset();
        for (int i = 0; i < 12; i++) apply_stimulus(1'b1, 1'b1, S_FARG, OP_NOP);

        // Asynchronous reset between edges, in cycle 5 of an ADD.
        do_reset();
        for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 1'b0, 4'd0, OP_ADD);
        @(negedge clk);
        state   = decode(m_op, m_cycle);
        step_en = 1'b1;
        push_expected(strobe_tab[state]);
        #2;
        reset = 1'b1;
        model_clear();
        push_expected(9'b0);
        @(negedge clk);
        reset   = 1'b0;
        step_en = 1'b0;
        run_instr(OP_LDA, -1, 0);

        // Random traffic: random step_en, opcodes and occasional forced states.
        for (int i = 0; i < 400; i++) begin
            if (m_halt || m_fault) do_reset();
            if ($urandom_range(0, 15) == 0)
                apply_stimulus(1'($urandom_range(0, 3) != 0), 1'b1, 4'($urandom_range(0, 15)), 4'd0);
            else
                apply_stimulus(1'($urandom_range(0, 3) != 0), 1'b0, 4'd0, 4'($urandom_range(0, 15)));
        end

        @(negedge clk);
        #3;
        if (expq.size() != 0) begin
            $display("[TB] FAIL drain: actual %0d pending expectations, expected 0", expq.size());
            n_bad++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
